// File: rtl/mdu_pkg.sv
// mdu_pkg: shared request encodings, FSM states and default width for the HI/LO multiply/divide unit.
package mdu_pkg;
    localparam int MDU_DATA_W = 32;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } mdu_state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate, used both for operand magnitudes and result re-signing.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO registers with iterative MULT/MULTU and MTHI/MTLO writes.
// Define MDU_DIV_EN to add iterative DIV/DIVU; otherwise ops 10/11 are accepted as no-ops.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int                DATA_W   = MDU_DATA_W,
    parameter logic [DATA_W-1:0] HILO_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              mt_hi_en,
    input  logic              mt_lo_en,
    input  logic [DATA_W-1:0] mt_data,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = $clog2(DATA_W);
    mdu_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc, acc_nxt, prod_fix;
    logic [DATA_W-1:0]     opb, abs_a, abs_b, hi_fix, lo_fix;
    logic [DATA_W:0]       mul_sum;
    logic                  sgn, neg_a, neg_b, legal, neg_hi;
    assign sgn       = (req_op == OP_MULT) || (req_op == OP_DIV);
    assign neg_a     = sgn & src_a[DATA_W-1];
    assign neg_b     = sgn & src_b[DATA_W-1];
    assign busy      = state != S_IDLE;
    assign req_ready = ~busy;
    mdu_sign_fix #(.W(DATA_W))   u_abs_a    (.val(src_a), .neg(neg_a),  .res(abs_a));
    mdu_sign_fix #(.W(DATA_W))   u_abs_b    (.val(src_b), .neg(neg_b),  .res(abs_b));
    mdu_sign_fix #(.W(2*DATA_W)) u_fix_prod (.val(acc),   .neg(neg_hi), .res(prod_fix));
    // acc low half holds the multiplier, shifted out as the product shifts in from the top
    assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
`ifdef MDU_DIV_EN
    logic              is_div, neg_lo, ge;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W-1:0] rem_nxt, q_fix, r_fix;
    assign legal   = 1'b1;
    // restoring divide: acc = {remainder, dividend/quotient}; a zero divisor yields all-ones and rem=dividend
    assign rem_sh  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign ge      = rem_sh >= {1'b0, opb};
    assign rem_nxt = ge ? DATA_W'(rem_sh - {1'b0, opb}) : rem_sh[DATA_W-1:0];
    assign acc_nxt = is_div ? {rem_nxt, acc[DATA_W-2:0], ge} : {mul_sum, acc[DATA_W-1:1]};
    mdu_sign_fix #(.W(DATA_W)) u_fix_r (.val(acc[2*DATA_W-1:DATA_W]), .neg(neg_hi), .res(r_fix));
    mdu_sign_fix #(.W(DATA_W)) u_fix_q (.val(acc[DATA_W-1:0]),        .neg(neg_lo), .res(q_fix));
    assign hi_fix  = is_div ? r_fix : prod_fix[2*DATA_W-1:DATA_W];
    assign lo_fix  = is_div ? q_fix : prod_fix[DATA_W-1:0];
`else
    assign legal   = (req_op == OP_MULT) || (req_op == OP_MULTU);
    assign acc_nxt = {mul_sum, acc[DATA_W-1:1]};
    assign hi_fix  = prod_fix[2*DATA_W-1:DATA_W];
    assign lo_fix  = prod_fix[DATA_W-1:0];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_hi <= 1'b0;
            done   <= 1'b0;
            hi     <= HILO_RST;
            lo     <= HILO_RST;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_lo <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mt_hi_en) hi <= mt_data;
                    if (mt_lo_en) lo <= mt_data;
                    if (req_valid && legal) begin
                        state <= S_CALC;
                        cnt   <= CNT_W'(DATA_W - 1);
                        acc   <= {{DATA_W{1'b0}}, abs_a};
                        opb   <= abs_b;
`ifdef MDU_DIV_EN
                        is_div <= req_op[1];
                        neg_hi <= req_op[1] ? neg_a : neg_a ^ neg_b;
                        neg_lo <= (neg_a ^ neg_b) & (|src_b);
`else
                        neg_hi <= neg_a ^ neg_b;
`endif
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed and randomized checks of hilo_mdu against a 64-bit arithmetic reference model.
module tb_hilo_mdu;
    import mdu_pkg::*;
    logic        clk = 1'b0;
    logic        rst, req_valid, mt_hi_en, mt_lo_en;
    logic [1:0]  req_op;
    logic [31:0] src_a, src_b, mt_data;
    logic        req_ready, busy, done;
    logic [31:0] hi, lo;
    logic [31:0] m_hi, m_lo, ra, rb;
    logic [31:0] spec_vals [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    int          n_cmp = 0, n_err = 0;
    hilo_mdu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .mt_hi_en(mt_hi_en), .mt_lo_en(mt_lo_en),
        .mt_data(mt_data), .req_ready(req_ready), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic is_legal(input logic [1:0] op);
`ifdef MDU_DIV_EN
        return 1'b1;
`else
        return !op[1];
`endif
    endfunction
    // {HI,LO} from plain signed/unsigned 64-bit arithmetic
    function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULT) return sa * sb;
        if (op == OP_MULTU) return 64'(a) * 64'(b);
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = longint'(a / b);
            r = longint'(a % b);
        end
        return {r[31:0], q[31:0]};
    endfunction
    function automatic logic [31:0] pick();
        return ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom();
    endfunction
    // issue one request (optionally with MT writes in the same cycle); poke>0 injects an ignored req + MTLO at that busy cycle
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mh, input logic ml, input logic [31:0] md, input int poke);
        logic        lg;
        logic [63:0] exp;
        int          n, d;
        lg = is_legal(op);
        n  = 0;
        d  = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        mt_hi_en = mh; mt_lo_en = ml; mt_data = md;
        @(negedge clk);
        req_valid = 1'b0; mt_hi_en = 1'b0; mt_lo_en = 1'b0;
        if (mh) m_hi = md;
        if (ml) m_lo = md;
        if (!lg) begin
            check({tag, "_busy"}, 64'(busy), 64'(0));
            check({tag, "_done"}, 64'(done), 64'(0));
            check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
            return;
        end
        exp = ref_mdu(op, a, b);
        while (busy && n < 100) begin
            n++;
            d += int'(done);
            if (n == 1) begin
                check({tag, "_ready"}, 64'(req_ready), 64'(0));
                check({tag, "_hi_calc"}, 64'(hi), 64'(m_hi));
            end
            req_valid = (n == poke); req_op = OP_MULTU; src_a = '1; src_b = '1;
            mt_lo_en = (n == poke); mt_data = 32'hDEADBEEF;
            @(negedge clk);
        end
        req_valid = 1'b0; mt_lo_en = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'(33));
        check({tag, "_early_done"}, 64'(d), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_hilo"}, {hi, lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask
    initial begin
        int d;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; src_a = '0; src_b = '0;
        mt_hi_en = 1'b0; mt_lo_en = 1'b0; mt_data = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        mt_hi_en = 1'b1; mt_data = 32'h12345678;
        @(negedge clk);
        mt_hi_en = 1'b0;
        check("mthi", 64'(hi), 64'h12345678);
        check("mthi_lo_kept", 64'(lo), 64'(0));
        m_hi = 32'h12345678;
        do_op("mult_neg", OP_MULT, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0, '0, 0);
        check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        do_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0, '0, 0);
        check("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
        do_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 1'b0, 1'b0, '0, 0);
        check("mult_min_const", {hi, lo}, 64'h40000000_00000000);
        do_op("mt_busy", OP_MULT, 32'd3, 32'd5, 1'b0, 1'b0, '0, 5);
        check("mt_busy_const", {hi, lo}, 64'd15);
        do_op("mt_same", OP_MULTU, 32'd7, 32'd6, 1'b1, 1'b1, 32'hCAFEF00D, 0);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        d = 0;
        repeat (40) begin
            @(negedge clk);
            d += int'(done);
        end
        check("rst_mid_no_done", 64'(d), 64'(0));
        check("rst_mid_hilo_after", {hi, lo}, 64'(0));
`ifdef MDU_DIV_EN
        do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, '0, 0);
        check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1'b0, 1'b0, '0, 0);
        check("divu_zero_const", {hi, lo}, 64'h00000005_FFFFFFFF);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 0);
        check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
`else
        do_op("mult_seed", OP_MULT, 32'h00010001, 32'hFFFF0003, 1'b0, 1'b0, '0, 0);
        do_op("div_noop", OP_DIV, 32'd10, 32'd3, 1'b0, 1'b0, '0, 0);
        do_op("divu_noop_mt", OP_DIVU, 32'd10, 32'd0, 1'b0, 1'b1, 32'h0BADC0DE, 0);
`endif
        for (int i = 0; i < 40; i++) begin
            ra = pick();
            rb = pick();
            do_op("rnd", 2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
